// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester-side command/response bundle plus the shared APB master command port
interface apb_req_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req, req_write, ack, gnt;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rsp_rdata, m_write_data, m_read_data;
   logic [AW-1:0]      m_write_addr, m_read_addr;
   logic               rsp_err, m_new_d, m_read, m_busy;
   modport slave (
      input  req, req_write, req_addr, req_wdata, m_read_data, m_busy,
      output ack, gnt, rsp_rdata, rsp_err, m_new_d, m_read, m_write_addr, m_read_addr, m_write_data
   );
   modport master (
      output req, req_write, req_addr, req_wdata, m_read_data, m_busy,
      input  ack, gnt, rsp_rdata, rsp_err, m_new_d, m_read, m_write_addr, m_read_addr, m_write_data
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master command port among NREQ requesters
module apb_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst,
   apb_req_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN} state_t;
   state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n, win;
   logic [15:0] cnt, cnt_n;
   logic [NREQ-1:0] ack, ack_n, gnt, gnt_n, rot;
   logic [DW-1:0] rdata, rdata_n, wdata, wdata_n;
   logic [AW-1:0] addr, addr_n;
   logic err, err_n, new_d, new_d_n, read, read_n;
   // rot[i] is the request of requester ptr+1+i, so the lowest set bit is the winner
   assign rot = NREQ'({bus.req, bus.req} >> (int'(ptr) + 1));
   always_comb begin
      win = ptr;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) win = PW'((int'(ptr) + 1 + i) % NREQ);
   end
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      cnt_n = cnt;
      ack_n = '0;
      gnt_n = gnt;
      rdata_n = rdata;
      err_n = err;
      new_d_n = 1'b0;
      read_n = read;
      addr_n = addr;
      wdata_n = wdata;
      case (state)
         IDLE:
            if (|bus.req && !bus.m_busy) begin
               state_n = ISSUE;
               gnt_n = '0;
               gnt_n[win] = 1'b1;
               ptr_n = win;
               cnt_n = '0;
               new_d_n = 1'b1;
               read_n = ~bus.req_write[win];
               addr_n = bus.req_addr[int'(win)*AW +: AW];
               wdata_n = bus.req_wdata[int'(win)*DW +: DW];
            end
         ISSUE: state_n = WAIT_BUSY;
         WAIT_BUSY:
            if (cnt == 16'(TIMEOUT)) begin
               state_n = DRAIN;
               ack_n = gnt;
               err_n = 1'b1;
            end else if (bus.m_busy) state_n = WAIT_DONE;
            else cnt_n = cnt + 16'd1;
         WAIT_DONE:
            if (cnt == 16'(TIMEOUT)) begin
               state_n = DRAIN;
               ack_n = gnt;
               err_n = 1'b1;
            end else if (!bus.m_busy) begin
               state_n = RESP;
               ack_n = gnt;
               err_n = 1'b0;
               rdata_n = read ? bus.m_read_data : rdata;
            end else cnt_n = cnt + 16'd1;
         RESP: begin
            state_n = IDLE;
            gnt_n = '0;
         end
         DRAIN: begin
            gnt_n = '0;
            if (!bus.m_busy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         ptr <= PW'(NREQ - 1);
         cnt <= '0;
         ack <= '0;
         gnt <= '0;
         rdata <= '0;
         err <= 1'b0;
         new_d <= 1'b0;
         read <= 1'b0;
         addr <= '0;
         wdata <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         cnt <= cnt_n;
         ack <= ack_n;
         gnt <= gnt_n;
         rdata <= rdata_n;
         err <= err_n;
         new_d <= new_d_n;
         read <= read_n;
         addr <= addr_n;
         wdata <= wdata_n;
      end
   assign bus.ack = ack;
   assign bus.gnt = gnt;
   assign bus.rsp_rdata = rdata;
   assign bus.rsp_err = err;
   assign bus.m_new_d = new_d;
   assign bus.m_read = read;
   assign bus.m_write_addr = addr;
   assign bus.m_read_addr = addr;
   assign bus.m_write_data = wdata;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table vectors, corner sequences and a random run against a transaction-level model
module tb_apb_req_arbiter;
   localparam int NREQ = 4;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;
   typedef struct {
      int idx;
      bit wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int blen;
      logic [DW-1:0] rdata;
      logic [NREQ-1:0] exp_gnt;
      logic exp_read;
      logic [DW-1:0] exp_rsp;
   } vec_t;
   logic clk, rst, hold, force_busy, stub_busy;
   logic [DW-1:0] cfg_rdata, stub_rdata, last_rd, o_addr, o_wdata;
   int cfg_len, errors = 0, checks = 0;
   int order[6] = '{0, 1, 2, 3, 0, 1};
   vec_t vecs[6];
   apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
   apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.m_busy = stub_busy | force_busy;
   assign bus.m_read_data = stub_rdata;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   // master stub: busy for a fixed or random number of cycles after each command strobe
   initial begin
      stub_busy = 1'b0;
      stub_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.m_new_d) begin
            stub_busy = 1'b1;
            repeat (cfg_len != 0 ? cfg_len : int'($urandom_range(2, 6))) @(negedge clk);
            while (hold) @(negedge clk);
            stub_rdata = cfg_len != 0 ? cfg_rdata : DW'($urandom);
            stub_busy = 1'b0;
         end
      end
   end
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_write[i] = wr;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_wdata[i*DW +: DW] = d;
   endtask
   task automatic wait_new_d(input int lim, output int n);
      n = 0;
      while (n < lim && !bus.m_new_d) begin
         @(negedge clk);
         n++;
      end
      chk("new_d_seen", bus.m_new_d, 1);
   endtask
   task automatic wait_ack(input int lim, output int n);
      n = 0;
      while (n < lim && bus.ack == '0) begin
         @(negedge clk);
         n++;
      end
      chk("ack_seen", |bus.ack, 1);
   endtask
   task automatic chk_zero(input string name);
      chk(name, {bus.ack, bus.gnt, bus.rsp_rdata, bus.rsp_err, bus.m_new_d, bus.m_read,
                 bus.m_write_addr, bus.m_read_addr, bus.m_write_data}, 0);
   endtask
   task automatic do_reset();
      rst = 1'b0;
      bus.req = '0;
      hold = 1'b0;
      force_busy = 1'b0;
      cfg_len = 0;
      repeat (2) @(negedge clk);
      chk_zero("reset_outputs");
      rst = 1'b1;
   endtask
   task automatic run_vec(input vec_t v);
      int n;
      cfg_len = v.blen;
      cfg_rdata = v.rdata;
      set_cmd(v.idx, v.wr, v.addr, v.wdata);
      bus.req[v.idx] = 1'b1;
      wait_new_d(10, n);
      chk("vec_gnt", bus.gnt, v.exp_gnt);
      chk("vec_read", bus.m_read, v.exp_read);
      chk("vec_waddr", bus.m_write_addr, v.addr);
      chk("vec_raddr", bus.m_read_addr, v.addr);
      chk("vec_wdata", bus.m_write_data, v.wdata);
      @(negedge clk);
      chk("vec_new_d_pulse", bus.m_new_d, 0);
      wait_ack(20, n);
      chk("vec_ack", bus.ack, v.exp_gnt);
      chk("vec_rdata", bus.rsp_rdata, v.exp_rsp);
      chk("vec_err", bus.rsp_err, 0);
      bus.req[v.idx] = 1'b0;
      @(negedge clk);
      chk("vec_ack_gnt_clear", {bus.ack, bus.gnt}, 0);
   endtask
   initial begin
      int n, w, ptr_m, owner, age;
      bit inflight, o_read;
      vecs[0] = '{0, 1'b1, 8'h10, 8'hA5, 3, 8'h00, 4'b0001, 1'b0, 8'h00};
      vecs[1] = '{2, 1'b0, 8'h22, 8'h00, 3, 8'h5C, 4'b0100, 1'b1, 8'h5C};
      vecs[2] = '{1, 1'b0, 8'hFF, 8'h00, 2, 8'h3C, 4'b0010, 1'b1, 8'h3C};
      vecs[3] = '{3, 1'b1, 8'h00, 8'hFF, 5, 8'h99, 4'b1000, 1'b0, 8'h3C};
      vecs[4] = '{0, 1'b0, 8'h80, 8'h11, 6, 8'h00, 4'b0001, 1'b1, 8'h00};
      vecs[5] = '{3, 1'b0, 8'h7E, 8'h22, 2, 8'hE1, 4'b1000, 1'b1, 8'hE1};
      rst = 1'b0;
      bus.req = '0;
      bus.req_write = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      hold = 1'b0;
      force_busy = 1'b0;
      cfg_len = 0;
      cfg_rdata = '0;
      do_reset();
      for (int t = 0; t < 6; t++) run_vec(vecs[t]);
      // contention: all four requesters, each re-requesting right after its ack
      do_reset();
      for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, AW'(8'h40 + i), DW'(8'hC0 + i));
      bus.req = '1;
      for (int t = 0; t < 6; t++) begin
         wait_new_d(20, n);
         chk("cont_onehot", $onehot(bus.gnt), 1);
         chk("cont_gnt", bus.gnt, 1 << order[t]);
         chk("cont_addr", bus.m_write_addr, 8'h40 + order[t]);
         wait_ack(30, n);
         chk("cont_ack", bus.ack, 1 << order[t]);
         bus.req[order[t]] = 1'b0;
         @(negedge clk);
         bus.req[order[t]] = 1'b1;
      end
      bus.req = '0;
      @(negedge clk);
      // timeout: master never drops busy
      do_reset();
      cfg_len = 3;
      cfg_rdata = 8'h6B;
      hold = 1'b1;
      set_cmd(0, 1'b0, 8'h55, 8'h00);
      bus.req[0] = 1'b1;
      wait_new_d(10, n);
      wait_ack(40, n);
      chk("to_latency", n, TO + 3);
      chk("to_ack", bus.ack, 4'b0001);
      chk("to_err", bus.rsp_err, 1);
      chk("to_rdata_kept", bus.rsp_rdata, 0);
      bus.req[0] = 1'b0;
      set_cmd(1, 1'b0, 8'h31, 8'h00);
      bus.req[1] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("to_drain_idle", {bus.gnt, bus.m_new_d, bus.ack}, 0);
      end
      hold = 1'b0;
      wait_new_d(10, n);
      chk("to_next_gnt", bus.gnt, 4'b0010);
      chk("to_next_raddr", bus.m_read_addr, 8'h31);
      wait_ack(20, n);
      chk("to_next_ack", bus.ack, 4'b0010);
      chk("to_next_err", bus.rsp_err, 0);
      chk("to_next_rdata", bus.rsp_rdata, 8'h6B);
      bus.req[1] = 1'b0;
      @(negedge clk);
      // master busy while idle: no grant until it clears
      do_reset();
      force_busy = 1'b1;
      cfg_len = 2;
      set_cmd(1, 1'b1, 8'h44, 8'h5A);
      bus.req[1] = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         chk("busy_idle_nogrant", {bus.gnt, bus.m_new_d}, 0);
      end
      force_busy = 1'b0;
      wait_new_d(10, n);
      chk("busy_idle_gnt", bus.gnt, 4'b0010);
      chk("busy_idle_wdata", bus.m_write_data, 8'h5A);
      wait_ack(20, n);
      chk("busy_idle_ack", bus.ack, 4'b0010);
      bus.req[1] = 1'b0;
      @(negedge clk);
      // reset during WAIT_DONE
      do_reset();
      cfg_len = 8;
      cfg_rdata = 8'hC3;
      set_cmd(2, 1'b1, 8'h12, 8'h34);
      bus.req[2] = 1'b1;
      wait_new_d(10, n);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_zero("rst_mid_async");
      bus.req[2] = 1'b0;
      set_cmd(3, 1'b0, 8'h3A, 8'h00);
      bus.req[3] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         chk("rst_mid_no_ack", bus.ack, 0);
      end
      rst = 1'b1;
      wait_new_d(30, n);
      chk("rst_mid_gnt", bus.gnt, 4'b1000);
      chk("rst_mid_raddr", bus.m_read_addr, 8'h3A);
      wait_ack(30, n);
      chk("rst_mid_ack", bus.ack, 4'b1000);
      chk("rst_mid_rdata", bus.rsp_rdata, 8'hC3);
      bus.req[3] = 1'b0;
      @(negedge clk);
      // random traffic against a transaction-level round-robin model
      do_reset();
      ptr_m = NREQ - 1;
      last_rd = '0;
      inflight = 1'b0;
      owner = 0;
      age = 0;
      o_read = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("rnd_gnt_onehot0", $onehot0(bus.gnt), 1);
         if (bus.m_new_d) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
               if (w < 0 && bus.req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
            chk("rnd_winner", bus.gnt, w < 0 ? 0 : 1 << w);
            if (w >= 0) begin
               o_read = !bus.req_write[w];
               o_addr = bus.req_addr[w*AW +: AW];
               o_wdata = bus.req_wdata[w*DW +: DW];
               chk("rnd_read", bus.m_read, o_read);
               chk("rnd_addr", {bus.m_write_addr, bus.m_read_addr}, {o_addr, o_addr});
               chk("rnd_wdata", bus.m_write_data, o_wdata);
               ptr_m = w;
               owner = w;
               inflight = 1'b1;
               age = 0;
            end
         end else if (bus.ack != '0) begin
            chk("rnd_ack", bus.ack, inflight ? 1 << owner : 0);
            if (o_read) last_rd = stub_rdata;
            chk("rnd_rdata", bus.rsp_rdata, last_rd);
            chk("rnd_err", bus.rsp_err, 0);
            chk("rnd_cmd_kept", {bus.m_write_addr, bus.m_write_data}, {o_addr, o_wdata});
            inflight = 1'b0;
         end else if (inflight && ++age > 40) begin
            chk("rnd_ack_bound", bus.ack, 1 << owner);
            inflight = 1'b0;
         end
         for (int i = 0; i < NREQ; i++)
            if (bus.ack[i]) bus.req[i] = 1'b0;
            else if (inflight && i == owner && bus.req[i] && $urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
            else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
               set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
               bus.req[i] = 1'b1;
            end
         if (inflight && $urandom_range(0, 3) == 0)
            set_cmd(owner, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master between NREQ independent requesters (CPU-side config port, DMA, debug, etc.).
- Arbitrates round-robin, latches the winner's command, drives the master's new_d/read/address/data command interface, and tracks completion through the master's Busy output.
- Returns read data and a one-cycle ack to the granted requester.
- A watchdog reports an error when the master stalls, for example when pready is never returned.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 255, maximum cycles spent in WAIT_BUSY plus WAIT_DONE before error (1..2^16-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, level; held until ack
- req_write  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DW  read data, valid while ack is high (read transfers)
- rsp_err  out  1  timeout flag, valid while ack is high
- gnt  out  NREQ  one-hot owner of the current transfer; 0 when idle
- m_new_d  out  1  command strobe to the master
- m_read  out  1  1 = read command to the master
- m_write_addr  out  AW  master write address
- m_read_addr  out  AW  master read address
- m_write_data  out  DW  master write data
- m_read_data  in  DW  master read-data output
- m_busy  in  1  master Busy

Behaviour:
- Reset (rst=0, async):
  - ack=0, gnt=0, rsp_rdata=0, rsp_err=0.
  - m_new_d=0, m_read=0, all m_* address/data outputs = 0.
  - State=IDLE, timeout counter=0, round-robin pointer=NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN.
- IDLE:
  - Grants when any req bit is set and m_busy=0.
  - Winner is the first set bit searching upward from pointer+1, with wrap-around.
  - On the grant edge: gnt<=onehot(winner), pointer<=winner; latch the winner's write/addr/wdata into m_read=~write, m_write_addr=m_read_addr=addr, m_write_data=wdata; m_new_d<=1; counter<=0; go to ISSUE.
  - With m_busy=1 in IDLE: no grant.
- ISSUE: m_new_d is high for exactly this one cycle. On the next edge m_new_d<=0 and the state goes to WAIT_BUSY.
- WAIT_BUSY:
  - m_busy=1 -> WAIT_DONE.
  - Otherwise counter increments.
- WAIT_DONE:
  - m_busy=0 -> rsp_rdata<=m_read_data (reads only; unchanged on writes), rsp_err<=0, ack<=gnt, go to RESP.
  - Otherwise counter increments.
- Timeout: if the counter reaches TIMEOUT in WAIT_BUSY or WAIT_DONE, then ack<=gnt, rsp_err<=1, rsp_rdata unchanged, go to DRAIN.
- RESP:
  - ack is high for this one cycle, then ack<=0, gnt<=0, state goes to IDLE.
  - Requester contract: deassert req on the edge at which ack=1 is sampled, so the following IDLE cycle does not see a stale request.
- DRAIN:
  - ack pulses as in RESP, then ack<=0 and gnt<=0 while waiting.
  - Waits for m_busy=0, then goes to IDLE. No new grant is made while the master is still busy.
- Latency: for an uncontended transfer, from req sampled high in IDLE to ack high is 4 cycles plus the master's busy duration.
- m_new_d is never asserted outside ISSUE, so the master always returns to its idle state between transfers (no back-to-back chaining).
- Requester inputs are ignored after the grant edge: changes to req_addr/req_wdata/req_write mid-transfer have no effect.
- A requester that drops req mid-transfer still completes and still receives ack.
- Simultaneous requests: exactly one grant. The pointer update guarantees that each active requester is served within NREQ transfers.
- Reset mid-transfer: everything returns to reset values immediately, and no ack is produced for the aborted transfer.

Test Plan:
- Single write: req[0]=1, write=1, addr=0x10, wdata=0xA5; master stub busy for 3 cycles -> m_new_d high 1 cycle, m_write_addr=0x10, m_write_data=0xA5, m_read=0; ack=4'b0001 for 1 cycle, rsp_err=0.
- Single read: req[2]=1, read addr=0x22; stub returns m_read_data=0x5C when busy falls -> m_read=1, m_read_addr=0x22; ack=4'b0100 with rsp_rdata=0x5C.
- Contention: req=4'b1111 held, each requester re-requesting after its ack -> grant order 0,1,2,3,0,1; exactly one gnt bit high at any time.
- Timeout: TIMEOUT=16, stub holds m_busy=1 indefinitely -> after 16 counted cycles ack=gnt with rsp_err=1; no new grant while m_busy=1; after busy falls, the next pending request is granted.
- Busy-at-idle: m_busy=1 while req[1]=1 in IDLE -> no grant and m_new_d=0 until m_busy=0.
- Reset mid-transfer: assert rst=0 during WAIT_DONE -> all outputs 0 asynchronously, no ack; after release with req[3]=1 -> requester 3 is served.
